// File: rtl/i2s_mic_receiver.sv
// Master-mode I2S receiver for an INMP441 MEMS microphone: drives sck/ws/lr and
// deserialises one 24-bit channel into a signed sample with a one-cycle strobe.
module i2s_mic_receiver #(
    parameter int clk_mhz  = 50,
    parameter int sck_half = 8,
    parameter int channel  = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               lr,
    output logic               ws,
    output logic               sck,
    input  logic               sd,
    output logic signed [23:0] value,
    output logic               value_valid
);
    localparam int         DATA_W   = 24;
    localparam logic [7:0] DIV_LAST = 8'(sck_half - 1);
    localparam logic       CH       = 1'(channel);

    if (sck_half < 4 || sck_half > 255 || clk_mhz < 1) begin : g_param_check
        $error("i2s_mic_receiver: sck_half must lie in 4..255");
    end

    // Slot bit 0 is the I2S one-bit delay; bits 25..31 are tri-stated by the mic.
    function automatic logic in_data_window(input logic [4:0] k);
        return (k != 5'd0) && (k <= 5'd24);
    endfunction

    logic [7:0]               div_cnt;
    logic [5:0]               bit_cnt;
    logic [5:0]               bit_cnt_nxt;
    logic [4:0]               slot_bit;
    logic                     div_wrap;
    logic                     capture;
    logic                     word_done;
    logic                     sd_p0;
    logic                     sd_p1;
    logic signed [DATA_W-1:0] shift_p2;
    logic                     vld_p2;

    assign lr          = CH;
    assign bit_cnt_nxt = bit_cnt + 6'd1;
    assign slot_bit    = bit_cnt[4:0];
    assign div_wrap    = (div_cnt == DIV_LAST);

    always_comb begin
        capture   = 1'b0;
        word_done = 1'b0;
        if (div_wrap && sck && (bit_cnt[5] == CH) && in_data_window(slot_bit)) begin
            capture   = 1'b1;
            word_done = (slot_bit == 5'd24);
        end
    end

    // Clock generation: ws and bit_cnt advance together on the sck falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
            bit_cnt <= '0;
            ws      <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            sck     <= ~sck;
            if (sck) begin
                bit_cnt <= bit_cnt_nxt;
                ws      <= bit_cnt_nxt[5];
            end
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Stage p0/p1: two-flop synchroniser for the asynchronous sd pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sd_p0 <= 1'b0;
            sd_p1 <= 1'b0;
        end else begin
            sd_p0 <= sd;
            sd_p1 <= sd_p0;
        end
    end

    // Stage p2: shift MSB-first; only in-window bits of our slot enter the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_p2 <= '0;
            vld_p2   <= 1'b0;
        end else begin
            vld_p2 <= word_done;
            if (capture) begin
                shift_p2 <= {shift_p2[DATA_W-2:0], sd_p1};
            end
        end
    end

    // Output stage: publish the completed word with a single-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            value       <= '0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= vld_p2;
            if (vld_p2) begin
                value <= shift_p2;
            end
        end
    end
endmodule
